// File: rtl/uart_rx_only.sv
// 8N1 UART receiver: 2-FF synchronised line, three-sample mid-bit majority vote,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_only #(
    parameter int BPS_NUM = 208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int HALF = BPS_NUM / 2;
    localparam int CW   = $clog2(BPS_NUM);

    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_NUM - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic start_edge;
    logic end_of_bit;
    logic decide;
    logic vote;

    assign start_edge = prev_q & ~sync2_q;
    assign end_of_bit = (cnt_q == CNT_LAST);
    assign decide     = (cnt_q == CNT_DEC);
    // The third sample is the live synchronised bit at the decision point.
    assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned
        // (which would infer a latch); flag pulses default low so they last one cycle.
        sync1_d = uart_rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && rx_ready) valid_d = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = end_of_bit ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) smp_d[0] = sync2_q;
            if (cnt_q == CNT_S1) smp_d[1] = sync2_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (start_edge) state_d = START;
            end
            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (end_of_bit) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d = {vote, shift_q[7:1]};
                if (end_of_bit) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!vote) begin
                        ferr_d = 1'b1;
                    end else if (valid_q && !rx_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
